// File: rtl/conv55_window_gen.sv
// conv55_window_gen: streaming 5x5 sliding-window generator.
// Takes one pixel per cycle in raster order and keeps four previous rows in
// line buffers. For every fully populated window it presents 25 pixels, row-major
// with row 0 the oldest, one cycle after the newest pixel is accepted.
module conv55_window_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_pixel,
    output logic [DATA_W-1:0] win_0,
    output logic [DATA_W-1:0] win_1,
    output logic [DATA_W-1:0] win_2,
    output logic [DATA_W-1:0] win_3,
    output logic [DATA_W-1:0] win_4,
    output logic [DATA_W-1:0] win_5,
    output logic [DATA_W-1:0] win_6,
    output logic [DATA_W-1:0] win_7,
    output logic [DATA_W-1:0] win_8,
    output logic [DATA_W-1:0] win_9,
    output logic [DATA_W-1:0] win_10,
    output logic [DATA_W-1:0] win_11,
    output logic [DATA_W-1:0] win_12,
    output logic [DATA_W-1:0] win_13,
    output logic [DATA_W-1:0] win_14,
    output logic [DATA_W-1:0] win_15,
    output logic [DATA_W-1:0] win_16,
    output logic [DATA_W-1:0] win_17,
    output logic [DATA_W-1:0] win_18,
    output logic [DATA_W-1:0] win_19,
    output logic [DATA_W-1:0] win_20,
    output logic [DATA_W-1:0] win_21,
    output logic [DATA_W-1:0] win_22,
    output logic [DATA_W-1:0] win_23,
    output logic [DATA_W-1:0] win_24,
    output logic              out_valid,
    output logic              frame_done
);

    function automatic int clogb2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res = res + 1;
        return res;
    endfunction

    localparam int CW = clogb2(IMG_W) + 1;
    localparam int RW = clogb2(IMG_H) + 1;
    localparam int AW = clogb2(IMG_W);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(4);
    localparam logic [RW-1:0] ROW_MIN  = RW'(4);

    logic [CW-1:0]     col_q, col_d, pos_c;
    logic [RW-1:0]     row_q, row_d, pos_r;
    logic [AW-1:0]     col_idx;
    logic              out_valid_q, out_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] win_q [25];
    logic [DATA_W-1:0] win_d [25];
    logic [DATA_W-1:0] new_col [5];
    logic [DATA_W-1:0] line_buf [4][IMG_W];

    // Position of the pixel on the input this cycle (sof forces the frame origin)
    // and the incoming right-hand window column read from the line buffers.
    always_comb begin
        pos_c      = in_sof ? '0 : col_q;
        pos_r      = in_sof ? '0 : row_q;
        col_idx    = pos_c[AW-1:0];
        new_col[0] = line_buf[3][col_idx];
        new_col[1] = line_buf[2][col_idx];
        new_col[2] = line_buf[1][col_idx];
        new_col[3] = line_buf[0][col_idx];
        new_col[4] = in_pixel;
    end

    // Next-state: counter advance, window shift and output strobes on acceptance.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (in_valid) begin
            if (pos_c == COL_LAST) begin
                col_d = '0;
                row_d = (pos_r == ROW_LAST) ? '0 : pos_r + 1'b1;
            end else begin
                col_d = pos_c + 1'b1;
                row_d = pos_r;
            end
            for (int unsigned i = 0; i < 5; i++) begin
                for (int unsigned j = 0; j < 4; j++) begin
                    win_d[5*i+j] = win_q[5*i+j+1];
                end
                win_d[5*i+4] = new_col[i];
            end
            out_valid_d  = (pos_r >= ROW_MIN) && (pos_c >= COL_MIN);
            frame_done_d = (pos_r == ROW_LAST) && (pos_c == COL_LAST);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int unsigned k = 0; k < 25; k++) win_q[k] <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Line buffers: each accepted pixel pushes its column one row down the chain
    // (reads above see the pre-write contents). Contents are never reset.
    always_ff @(posedge clk) begin
        if (!rst && in_valid) begin
            line_buf[0][col_idx] <= in_pixel;
            line_buf[1][col_idx] <= line_buf[0][col_idx];
            line_buf[2][col_idx] <= line_buf[1][col_idx];
            line_buf[3][col_idx] <= line_buf[2][col_idx];
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign win_0  = win_q[0];
    assign win_1  = win_q[1];
    assign win_2  = win_q[2];
    assign win_3  = win_q[3];
    assign win_4  = win_q[4];
    assign win_5  = win_q[5];
    assign win_6  = win_q[6];
    assign win_7  = win_q[7];
    assign win_8  = win_q[8];
    assign win_9  = win_q[9];
    assign win_10 = win_q[10];
    assign win_11 = win_q[11];
    assign win_12 = win_q[12];
    assign win_13 = win_q[13];
    assign win_14 = win_q[14];
    assign win_15 = win_q[15];
    assign win_16 = win_q[16];
    assign win_17 = win_q[17];
    assign win_18 = win_q[18];
    assign win_19 = win_q[19];
    assign win_20 = win_q[20];
    assign win_21 = win_q[21];
    assign win_22 = win_q[22];
    assign win_23 = win_q[23];
    assign win_24 = win_q[24];

endmodule

// File: tb/tb_conv55_window_gen.sv
// Testbench for conv55_window_gen at default 28x28, 6-bit pixels.
// A reference image model predicts every output cycle; predictions go through a
// scoreboard queue and are compared after each clock edge.
module tb_conv55_window_gen;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int NP = W * H;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_sof;
    logic [5:0] in_pixel;
    logic [5:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9;
    logic [5:0] win_10, win_11, win_12, win_13, win_14, win_15, win_16, win_17, win_18, win_19;
    logic [5:0] win_20, win_21, win_22, win_23, win_24;
    logic       out_valid;
    logic       frame_done;
    logic [149:0] dut_win;

    conv55_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .win_0(win_0), .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4),
        .win_5(win_5), .win_6(win_6), .win_7(win_7), .win_8(win_8), .win_9(win_9),
        .win_10(win_10), .win_11(win_11), .win_12(win_12), .win_13(win_13), .win_14(win_14),
        .win_15(win_15), .win_16(win_16), .win_17(win_17), .win_18(win_18), .win_19(win_19),
        .win_20(win_20), .win_21(win_21), .win_22(win_22), .win_23(win_23), .win_24(win_24),
        .out_valid(out_valid), .frame_done(frame_done)
    );

    assign dut_win = {win_24, win_23, win_22, win_21, win_20, win_19, win_18, win_17,
                      win_16, win_15, win_14, win_13, win_12, win_11, win_10, win_9,
                      win_8, win_7, win_6, win_5, win_4, win_3, win_2, win_1, win_0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic         done;
        logic         chk_win;
        logic [149:0] win;
    } exp_t;

    typedef struct {
        int         idx;
        logic       ev;
        logic       ed;
        logic [5:0] w0;
        logic [5:0] w4;
        logic [5:0] w20;
        logic [5:0] w24;
    } vec_t;

    exp_t         sb[$];
    int           done_idx[$];
    logic [5:0]   img [H][W];
    int           m_row, m_col;
    int           tests, fails;
    int           acc_cnt, first_valid, nv, nd;
    logic [149:0] first_win;
    logic [149:0] ramp_first;

    function automatic void chk(input string name, input logic [149:0] act, input logic [149:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [5:0] ramp(input int n, input int off);
        return 6'((n + off) % 64);
    endfunction

    // One clock: predict, drive, sample, compare.
    task automatic step(input logic v, input logic s, input logic [5:0] p, input logic r);
        exp_t e;
        int   pr, pc, cur;
        e.valid = 1'b0; e.done = 1'b0; e.chk_win = 1'b0; e.win = '0;
        cur = -1;
        in_valid = v; in_sof = s; in_pixel = p; rst = r;
        if (r) begin
            m_row = 0; m_col = 0;
            e.chk_win = 1'b1;
        end else if (v) begin
            cur = acc_cnt;
            acc_cnt++;
            pr = s ? 0 : m_row;
            pc = s ? 0 : m_col;
            img[pr][pc] = p;
            if (pr >= 4 && pc >= 4) begin
                e.valid = 1'b1;
                e.chk_win = 1'b1;
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        e.win[(5*i+j)*6 +: 6] = img[pr-4+i][pc-4+j];
            end
            e.done = (pr == H-1) && (pc == W-1);
            if (pc == W-1) begin
                m_col = 0;
                m_row = (pr == H-1) ? 0 : pr + 1;
            end else begin
                m_col = pc + 1;
                m_row = pr;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("out_valid", 150'(out_valid), 150'(e.valid));
        chk("frame_done", 150'(frame_done), 150'(e.done));
        if (e.chk_win) chk("window", dut_win, e.win);
        if (out_valid === 1'b1) begin
            nv++;
            if (first_valid < 0) begin
                first_valid = cur;
                first_win = dut_win;
            end
        end
        if (frame_done === 1'b1) begin
            nd++;
            done_idx.push_back(cur);
        end
    endtask

    task automatic clear_stats();
        acc_cnt = 0; first_valid = -1; nv = 0; nd = 0;
        done_idx.delete();
    endtask

    vec_t tbl[8];
    int   ti;

    initial begin
        tests = 0; fails = 0; m_row = 0; m_col = 0;
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
        clear_stats();
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                ramp_first[(5*i+j)*6 +: 6] = ramp(W*i + j, 0);

        tbl[0] = '{idx: 0,   ev: 1'b0, ed: 1'b0, w0: 6'd0,  w4: 6'd0,  w20: 6'd0,  w24: 6'd0};
        tbl[1] = '{idx: 115, ev: 1'b0, ed: 1'b0, w0: 6'd0,  w4: 6'd0,  w20: 6'd0,  w24: 6'd0};
        tbl[2] = '{idx: 116, ev: 1'b1, ed: 1'b0, w0: 6'd0,  w4: 6'd4,  w20: 6'd48, w24: 6'd52};
        tbl[3] = '{idx: 139, ev: 1'b1, ed: 1'b0, w0: 6'd23, w4: 6'd27, w20: 6'd7,  w24: 6'd11};
        tbl[4] = '{idx: 140, ev: 1'b0, ed: 1'b0, w0: 6'd0,  w4: 6'd0,  w20: 6'd0,  w24: 6'd0};
        tbl[5] = '{idx: 144, ev: 1'b1, ed: 1'b0, w0: 6'd28, w4: 6'd32, w20: 6'd12, w24: 6'd16};
        tbl[6] = '{idx: 782, ev: 1'b1, ed: 1'b0, w0: 6'd26, w4: 6'd30, w20: 6'd10, w24: 6'd14};
        tbl[7] = '{idx: 783, ev: 1'b1, ed: 1'b1, w0: 6'd27, w4: 6'd31, w20: 6'd11, w24: 6'd15};

        // Reset with random inputs for two cycles.
        for (int k = 0; k < 2; k++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'b1);

        // Full continuous frame, no sof: the first pixel after reset must land at (0,0).
        clear_stats();
        ti = 0;
        for (int n = 0; n < NP; n++) begin
            step(1'b1, 1'b0, ramp(n, 0), 1'b0);
            if (ti < 8 && tbl[ti].idx == n) begin
                chk("tbl_valid", 150'(out_valid), 150'(tbl[ti].ev));
                chk("tbl_done", 150'(frame_done), 150'(tbl[ti].ed));
                if (tbl[ti].ev) begin
                    chk("tbl_w0", 150'(win_0), 150'(tbl[ti].w0));
                    chk("tbl_w4", 150'(win_4), 150'(tbl[ti].w4));
                    chk("tbl_w20", 150'(win_20), 150'(tbl[ti].w20));
                    chk("tbl_w24", 150'(win_24), 150'(tbl[ti].w24));
                end
                ti++;
            end
        end
        chk("full_nvalid", 150'(nv), 150'(576));
        chk("full_ndone", 150'(nd), 150'(1));
        chk("full_first_idx", 150'(first_valid), 150'(116));

        // Gapped input: random idle cycles between pixels.
        clear_stats();
        for (int n = 0; n < NP; n++) begin
            while ($urandom_range(0, 1) == 0)
                step(1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'b0);
            step(1'b1, n == 0, ramp(n, 0), 1'b0);
        end
        chk("gap_nvalid", 150'(nv), 150'(576));
        chk("gap_ndone", 150'(nd), 150'(1));
        chk("gap_first_win", first_win, ramp_first);

        // Back-to-back frames with no gap.
        clear_stats();
        for (int f = 0; f < 2; f++) begin
            first_valid = -1;
            for (int n = 0; n < NP; n++) step(1'b1, n == 0, ramp(n, 0), 1'b0);
            chk("b2b_first_win", first_win, ramp_first);
        end
        chk("b2b_nvalid", 150'(nv), 150'(1152));
        chk("b2b_ndone", 150'(nd), 150'(2));
        if (done_idx.size() == 2)
            chk("b2b_done_gap", 150'(done_idx[1] - done_idx[0]), 150'(784));
        else
            chk("b2b_done_count", 150'(done_idx.size()), 150'(2));

        // Mid-frame resync: abandon at (10,5), restart with a different ramp.
        clear_stats();
        for (int n = 0; n < 10*W + 5; n++) step(1'b1, 1'b0, ramp(n, 0), 1'b0);
        chk("resync_no_done", 150'(nd), 150'(0));
        clear_stats();
        for (int n = 0; n < NP; n++) step(1'b1, n == 0, ramp(n, 7), 1'b0);
        chk("resync_first_idx", 150'(first_valid), 150'(116));
        chk("resync_nvalid", 150'(nv), 150'(576));
        chk("resync_ndone", 150'(nd), 150'(1));

        // Reset mid-frame at pixel (6,6) while out_valid is high.
        clear_stats();
        for (int n = 0; n < 6*W + 6; n++) step(1'b1, n == 0, ramp(n, 3), 1'b0);
        chk("pre_rst_valid", 150'(out_valid), 150'(1));
        step(1'b1, 1'b0, ramp(6*W + 6, 3), 1'b1);
        clear_stats();
        for (int n = 0; n < NP; n++) step(1'b1, 1'b0, ramp(n, 11), 1'b0);
        chk("post_rst_nvalid", 150'(nv), 150'(576));
        chk("post_rst_ndone", 150'(nd), 150'(1));

        step(1'b0, 1'b0, 6'd0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv55_window_gen.md
# conv55_window_gen

Streaming 5x5 sliding-window generator that sits directly upstream of the 5x5 PIM convolution stage. It accepts one 6-bit feature-map pixel per cycle in raster order and buffers four previous image rows internally. For every fully populated window it presents the 25 pixels on `win_0..win_24` in the same row-major order as the conv stage's `in_data_0..in_data_24`. Valid-mode convolution, stride 1, no padding.

## Interface
- `IMG_W`, default 28: image width in pixels; must be ≥ 5.
- `IMG_H`, default 28: image height in rows; must be ≥ 5.
- `DATA_W`, default 6: pixel width; matches the conv stage input width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  pixel strobe; the pixel is accepted when high. There is no backpressure.
- `in_sof`  in  1  start-of-frame; qualified by `in_valid`.
- `in_pixel`  in  DATA_W  pixel value.
- `win_0` … `win_24`  out  DATA_W each  window pixels; `win_(5i+j)` is row i, column j, with row 0 the oldest.
- `out_valid`  out  1  the window outputs hold a complete window.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame.

## Operation
- Position counters:
  - `col` is clogb2(IMG_W)+1 bits; `row` is clogb2(IMG_H)+1 bits.
  - Both give the (r,c) position of the next accepted pixel.
- Accept rule: on `in_valid`=1, the pixel is assigned position (r,c) from the counters.
  - If `in_sof`=1 in the same cycle, the position is forced to (0,0) regardless of the counters.
- Counter advance after each accepted pixel:
  - c<IMG_W-1: c+1.
  - c=IMG_W-1, r<IMG_H-1: c=0, r+1.
  - c=IMG_W-1, r=IMG_H-1: c=0, r=0. This wraps to the next frame.
- Line storage:
  - Four row buffers of IMG_W×DATA_W, addressed by column, written and read in the same cycle (read-before-write).
  - Row buffers chain the pixel at column c down one row each time a pixel is accepted at that column.
  - Window storage is a 5×5 register array that shifts left by one column per accepted pixel.
  - The new right column is, from top to bottom: buf3[c], buf2[c], buf1[c], buf0[c], `in_pixel`.
- Window contents: the cycle after pixel (r,c) is accepted, `win_(5i+j)` = pixel(r-4+i, c-4+j).
  - `win_24` is the newest pixel.
  - `win_0` is pixel(r-4, c-4).
- `out_valid` is asserted the cycle after acceptance iff r≥4 and c≥4. Otherwise it is 0.
  - Window registers may hold stale or partial data whenever `out_valid`=0; the consumer ignores them.
- Valid windows per frame: (IMG_H-4)×(IMG_W-4), which is 576 at the defaults.
- Idle cycles (`in_valid`=0):
  - Counters, buffers and window registers hold.
  - `out_valid`=0 and `frame_done`=0.
- `frame_done`=1 the cycle after pixel (IMG_H-1, IMG_W-1) is accepted, coincident with the final `out_valid`.
- `in_sof` mid-frame: the partial frame is abandoned, with no `frame_done`. Rows 0–3 of the new frame then refill the buffers before any valid window.
- Reset:
  - Clears `row`, `col`, `out_valid`, `frame_done` and all window registers to 0.
  - Row-buffer contents are not cleared; the `out_valid` gating makes them don't-care.
  - The first pixel after reset is (0,0).

## Timing
- Latency is 1 cycle from pixel acceptance to the window/`out_valid`/`frame_done` update.
- Throughput is one pixel per cycle sustained, with no stall cycles, including across row and frame boundaries.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Back-to-back frames: pixel (0,0) of frame N+1 may be accepted in the cycle immediately after the last pixel of frame N. Its `frame_done` pulse and the new frame's first cycle do not interfere.
- `rst` has priority over `in_valid` and `in_sof` in the same cycle. The pixel is dropped.

## Test plan
- **Reset values:** assert `rst` 2 cycles with random inputs → all `win_k`=0, `out_valid`=0, `frame_done`=0; the first post-reset pixel is at (0,0).
- **Full frame, defaults:** continuous ramp pixel=(28r+c) mod 64.
  - First `out_valid` appears the cycle after the 117th pixel, with `win_0`=0, `win_4`=4, `win_20`=112 mod 64=48, `win_24`=116 mod 64=52.
  - Exactly 576 `out_valid` cycles.
  - `frame_done` pulses once, with the last window `win_24`=(28·27+27) mod 64=15.
- **Gapped input:** same frame with `in_valid` toggled by a random 50% pattern → identical sequence of 576 windows; `out_valid`=0 on every idle cycle.
- **Back-to-back frames:** two frames with no gap → 1152 valid windows, two `frame_done` pulses 784 accepted pixels apart, and the first window of frame 2 is identical to that of frame 1.
- **Mid-frame resync:** assert `in_sof` at pixel (10,5), then send a full frame → no `frame_done` for the aborted frame; the next window appears after the 117th pixel counted from the `in_sof` pixel.
- **Reset mid-frame:** assert `rst` at pixel (6,6) with `out_valid` high → `out_valid`=0 the next cycle; a subsequent full frame produces 576 correct windows.
